// File: rtl/barrel_shifter_rpipe_pkg.sv
// -----------------------------------------------------------------------------
// barrel_pkg
//
// Shared constants for the pipelined right barrel shifter and its benches.
//   BARREL_WIDTH  default datapath width
//   shamt_width() shift-amount width (and pipeline depth) for a given width
//   STAGE_*       stage index constants used by benches to name pipe positions
// -----------------------------------------------------------------------------
package barrel_pkg;

  localparam int BARREL_WIDTH = 8;

  // One pipeline stage per shift-amount bit, so this is also the stage count.
  function automatic int shamt_width(input int width);
    return $clog2(width);
  endfunction

  localparam int BARREL_SHW   = shamt_width(BARREL_WIDTH);
  localparam int STAGE_FIRST  = 0;
  localparam int STAGE_LAST   = BARREL_SHW - 1;
  localparam int PIPE_LATENCY = BARREL_SHW;

endpackage : barrel_pkg

// File: rtl/barrel_shifter_rpipe_rstage.sv
// -----------------------------------------------------------------------------
// barrel_rstage
//
// One registered stage of the right barrel shifter. Stage K shifts (or
// rotates) its input right by 2^K when amount bit K is set, and carries the
// remaining higher amount bits forward for the stages after it.
//
// Build option: define BSHR_ROTATE_EN to rotate instead of zero-filling.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   up_valid     item offered by the previous stage (or the block input)
//   up_ready     this stage can take an item this cycle
//   up_data      data from upstream
//   up_shamt     shift amount from upstream; bit K is consumed here
//   dn_valid     this stage holds an item
//   dn_ready     the next stage (or the block output) takes it this cycle
//   dn_data      registered, transformed data
//   dn_shamt     registered amount bits above K (bits K and below cleared)
// -----------------------------------------------------------------------------
module barrel_rstage
  import barrel_pkg::*;
#(
  parameter int WIDTH = BARREL_WIDTH,
  parameter int SHW   = shamt_width(WIDTH),
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  input  logic [SHW-1:0]   up_shamt,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_data,
  output logic [SHW-1:0]   dn_shamt
);

  localparam int STEP = 1 << K;

  // Keeps only the amount bits that later stages still need.
  function automatic logic [SHW-1:0] resid_mask();
    logic [SHW-1:0] m;
    m = '0;
    for (int i = K + 1; i < SHW; i++) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [SHW-1:0] RESID_MASK = resid_mask();

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [SHW-1:0]   shamt_q, shamt_d;
  logic [WIDTH-1:0] shifted;

`ifdef BSHR_ROTATE_EN
  // Shifting the doubled word right brings the low bits back in at the top.
  logic [2*WIDTH-1:0] doubled;

  always_comb begin
    doubled = {up_data, up_data} >> STEP;
    shifted = up_shamt[K] ? doubled[WIDTH-1:0] : up_data;
  end
`else
  always_comb begin
    shifted = up_shamt[K] ? (up_data >> STEP) : up_data;
  end
`endif

  // An empty stage always accepts, so bubbles collapse under a stall.
  assign up_ready = !valid_q || dn_ready;

  always_comb begin
    // NOTE: every variable gets its hold value first, so no branch can leave
    // one unassigned and infer a latch.
    valid_d = valid_q;
    data_d  = data_q;
    shamt_d = shamt_q;
    if (up_ready) begin
      valid_d = up_valid;
      // A bubble only clears valid; data keeps its last value.
      if (up_valid) begin
        data_d  = shifted;
        shamt_d = up_shamt & RESID_MASK;
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every stage samples
  // the pre-edge value of its neighbour. Data is reset too, not just valid,
  // so out_data reads zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      shamt_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      shamt_q <= shamt_d;
    end
  end

  assign dn_valid = valid_q;
  assign dn_data  = data_q;
  assign dn_shamt = shamt_q;

endmodule : barrel_rstage

// File: rtl/barrel_shifter_rpipe.sv
// -----------------------------------------------------------------------------
// barrel_shifter_rpipe
//
// Pipelined right barrel shifter with a valid/ready stream on each side.
// SHW registered stages, one per shift-amount bit; one item per cycle when
// the output is not stalled, SHW items in flight at most.
//
// Build option: define BSHR_ROTATE_EN for rotate-right instead of logical
// right shift. Latency and handshake are the same in both builds.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     input item offered
//   in_ready     input item accepted this cycle (combinational from out_ready)
//   in_data      operand
//   in_shamt     right-shift amount, 0..WIDTH-1
//   out_valid    result presented
//   out_ready    downstream accepts the result this cycle
//   out_data     shifted result
// -----------------------------------------------------------------------------
module barrel_shifter_rpipe
  import barrel_pkg::*;
#(
  parameter int WIDTH = BARREL_WIDTH,
  parameter int SHW   = shamt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  // Index k is the output of stage k; ready[SHW] is the downstream ready.
  logic             valid [SHW];
  logic [WIDTH-1:0] data  [SHW];
  logic [SHW-1:0]   shamt [SHW];
  logic             ready [SHW+1];

  assign ready[SHW] = out_ready;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;
    logic [SHW-1:0]   up_shamt;

    if (k == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = in_data;
      assign up_shamt = in_shamt;
    end else begin : g_body
      assign up_valid = valid[k-1];
      assign up_data  = data[k-1];
      assign up_shamt = shamt[k-1];
    end

    barrel_rstage #(
      .WIDTH (WIDTH),
      .SHW   (SHW),
      .K     (k)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (up_valid),
      .up_ready (ready[k]),
      .up_data  (up_data),
      .up_shamt (up_shamt),
      .dn_valid (valid[k]),
      .dn_ready (ready[k+1]),
      .dn_data  (data[k]),
      .dn_shamt (shamt[k])
    );
  end

  // The last stage has no consumer for its residual amount (always zero).
  logic unused_last_shamt;
  assign unused_last_shamt = ^shamt[SHW-1];

  assign in_ready  = ready[0];
  assign out_valid = valid[SHW-1];
  assign out_data  = data[SHW-1];

endmodule : barrel_shifter_rpipe

// File: tb/tb_barrel_shifter_rpipe.sv
// -----------------------------------------------------------------------------
// tb_barrel_shifter_rpipe
//
// Directed bench for barrel_shifter_rpipe at WIDTH=8. Expected results are
// hand-computed for both builds; BSHR_ROTATE_EN selects the rotate column.
// -----------------------------------------------------------------------------
module tb_barrel_shifter_rpipe;
  import barrel_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_shamt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] d;
    logic [2:0] s;
    logic [7:0] e_lsr;
    logic [7:0] e_rot;
  } vec_t;

  vec_t tab [8];

  barrel_shifter_rpipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pick(input logic [7:0] lsr, input logic [7:0] rot);
`ifdef BSHR_ROTATE_EN
    return rot;
`else
    return lsr;
`endif
  endfunction

  function automatic vec_t mk(input logic [7:0] d, input logic [2:0] s,
                              input logic [7:0] l, input logic [7:0] r);
    vec_t v;
    v.d = d; v.s = s; v.e_lsr = l; v.e_rot = r;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one item with out_ready high and measure edges until out_valid.
  task automatic send_one(input string tag, input logic [7:0] d, input logic [2:0] s,
                          input logic [7:0] e);
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    in_shamt  = s;
    #1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_shamt = 3'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd3);
    check({tag, "_data"}, 32'(out_data), 32'(e));
    step();
    check({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  // Stream all 8 table items; out_ready is low for stall_len cycles from
  // stall_from. Output beats are checked in order as they transfer.
  task automatic run_stream(input string tag, input int stall_from, input int stall_len,
                            output int acc_stall, output logic rdy_end_stall,
                            output logic rdy_release);
    int         in_idx;
    int         out_idx;
    int         extra;
    logic       held_v;
    logic [7:0] held_d;
    logic       stalled;
    in_idx = 0; out_idx = 0; extra = 0;
    held_v = 1'b0; held_d = '0;
    acc_stall = 0; rdy_end_stall = 1'b1; rdy_release = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (out_idx == 8) break;
      stalled   = (cyc >= stall_from) && (cyc < stall_from + stall_len);
      out_ready = !stalled;
      in_valid  = (in_idx < 8);
      in_data   = in_valid ? tab[in_idx].d : 8'($urandom);
      in_shamt  = in_valid ? tab[in_idx].s : 3'($urandom);
      #1;
      if (held_v) check({tag, "_hold"}, 32'(out_data), 32'(held_d));
      if (stall_len == 0) begin
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_valid"}, 32'(out_valid), 32'(cyc >= 3));
      end
      if (stalled && in_valid && in_ready) acc_stall++;
      if (stall_len > 0 && cyc == stall_from + stall_len - 1) rdy_end_stall = in_ready;
      if (stall_len > 0 && cyc == stall_from + stall_len) rdy_release = in_ready;
      if (in_valid && in_ready) in_idx++;
      if (out_valid && out_ready) begin
        check($sformatf("%s_beat%0d", tag, out_idx), 32'(out_data),
              32'(pick(tab[out_idx].e_lsr, tab[out_idx].e_rot)));
        out_idx++;
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
      step();
    end
    check({tag, "_count"}, 32'(out_idx), 32'd8);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (out_valid) extra++;
      step();
    end
    check({tag, "_no_dup"}, 32'(extra), 32'd0);
  endtask

  initial begin
    int   acc;
    int   seen;
    logic r_end;
    logic r_rel;

    //            data   sh    lsr    rot
    tab[0] = mk(8'hB4, 3'd3, 8'h16, 8'h96);
    tab[1] = mk(8'hA5, 3'd0, 8'hA5, 8'hA5);
    tab[2] = mk(8'hFF, 3'd7, 8'h01, 8'hFF);
    tab[3] = mk(8'h80, 3'd7, 8'h01, 8'h01);
    tab[4] = mk(8'h01, 3'd1, 8'h00, 8'h80);
    tab[5] = mk(8'h3C, 3'd2, 8'h0F, 8'h0F);
    tab[6] = mk(8'hC3, 3'd4, 8'h0C, 8'h3C);
    tab[7] = mk(8'h96, 3'd5, 8'h04, 8'hB4);

    // Reset held with random activity on the inputs.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid  = 1'($urandom);
      in_data   = 8'($urandom);
      in_shamt  = 3'($urandom);
      out_ready = 1'($urandom);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'h00);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (out_valid) seen++;
    end
    check("post_rst_idle", 32'(seen), 32'd0);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Single items and amount boundaries.
    send_one("single", 8'hB4, 3'd3, pick(8'h16, 8'h96));
    send_one("shamt0", 8'hA5, 3'd0, pick(8'hA5, 8'hA5));
    send_one("shamt7", 8'hFF, 3'd7, pick(8'h01, 8'hFF));

    // Back-to-back streaming with no stall.
    run_stream("stream", 0, 0, acc, r_end, r_rel);

    // Backpressure: out_ready low for the first 5 cycles of a stream.
    run_stream("bp", 0, 5, acc, r_end, r_rel);
    check("bp_accepted", 32'(acc), 32'd3);
    check("bp_full_in_ready", 32'(r_end), 32'd0);
    check("bp_release_in_ready", 32'(r_rel), 32'd1);

    // Reset with two items in flight.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hB4;
    in_shamt  = 3'd3;
    step();
    in_data   = 8'hC3;
    in_shamt  = 3'd4;
    step();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (out_valid) seen++;
    end
    check("midrst_discard", 32'(seen), 32'd0);
    send_one("post_midrst", 8'h6A, 3'd6, pick(8'h01, 8'hA9));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_barrel_shifter_rpipe
